icache_direct: RTL and testbench

- Direct-mapped instruction cache between the CPU instruction port (SRAM-like req/addr_ok/data_ok) and the AXI read-address/read-data channels.
- Cacheable fetches are served from on-chip RAM and refilled by whole-line INCR bursts.
- Uncached fetches (inst_cache=0) are forwarded as single-beat reads.
- One miss outstanding at a time; hits pipelined at one per cycle.

---
 rtl/icache_direct_pkg.sv | 19 +
 rtl/icache_sram.sv | 20 ++
 rtl/icache_direct.sv | 156 +++++++++++++++
 tb/tb_icache_direct.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_direct_pkg.sv
// Shared defaults, FSM encoding and line-geometry helper for the direct-mapped I-cache.
package icache_direct_pkg;

    localparam int ICACHE_IDX_BITS = 7;
    localparam int ICACHE_OFF_BITS = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        AR     = 3'd2,
        REFILL = 3'd3,
        DONE   = 3'd4
    } state_t;

    function automatic int line_words(input int off_bits);
        return 1 << (off_bits - 2);
    endfunction

endpackage

// File: rtl/icache_sram.sv
// Single-port synchronous-read RAM: one-cycle read latency, write enable, no reset.
module icache_sram #(
    parameter int AW = 7,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache: CPU SRAM-like port to AXI AR/R, whole-line refill.
// Define ICACHE_PERF_CNT_EN to add hit_cnt/miss_cnt outputs.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int IDX_BITS = ICACHE_IDX_BITS,
    parameter int OFF_BITS = ICACHE_OFF_BITS
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_cache,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic [31:0] inst_rdata,
    output logic        inst_data_ok,
    output logic [31:0] axi_araddr,
    output logic [7:0]  axi_arlen,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    input  logic [31:0] axi_rdata,
    input  logic        axi_rlast,
    input  logic        axi_rvalid,
    output logic        axi_rready
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int WB   = OFF_BITS - 2;
    localparam int LW   = line_words(OFF_BITS);
    localparam int TB   = 32 - IDX_BITS - OFF_BITS;
    localparam int SETS = 1 << IDX_BITS;

    state_t              state, state_nx;
    logic [31:0]         req_addr;
    logic                req_cache;
    logic [SETS-1:0]     valid;
    logic [31:0]         cap_word;
    logic [WB-1:0]       beat_idx;
    logic [TB-1:0]       tag_rd;
    logic [31:0]         data_rd;

    logic [TB-1:0]       req_tag;
    logic [IDX_BITS-1:0] req_idx, in_idx;
    logic [WB-1:0]       req_word, in_word;
    logic                hit, beat, tag_we, data_we;

    assign req_tag  = req_addr[31:IDX_BITS+OFF_BITS];
    assign req_idx  = req_addr[IDX_BITS+OFF_BITS-1:OFF_BITS];
    assign req_word = req_addr[OFF_BITS-1:2];
    assign in_idx   = inst_addr[IDX_BITS+OFF_BITS-1:OFF_BITS];
    assign in_word  = inst_addr[OFF_BITS-1:2];

    assign hit     = (state == LOOKUP) && req_cache && valid[req_idx] && (tag_rd == req_tag);
    assign beat    = axi_rvalid && axi_rready;
    assign data_we = beat && req_cache;
    assign tag_we  = beat && axi_rlast && req_cache;

    // RAM port is shared: refill writes win, otherwise read for the address being offered.
    icache_sram #(.AW(IDX_BITS), .DW(TB)) u_tag (
        .clk   (clk),
        .we    (tag_we),
        .addr  (tag_we ? req_idx : in_idx),
        .wdata (req_tag),
        .rdata (tag_rd)
    );

    icache_sram #(.AW(IDX_BITS + WB), .DW(32)) u_data (
        .clk   (clk),
        .we    (data_we),
        .addr  (data_we ? {req_idx, beat_idx} : {in_idx, in_word}),
        .wdata (axi_rdata),
        .rdata (data_rd)
    );

    always_comb begin
        state_nx     = state;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        axi_arvalid  = 1'b0;
        axi_rready   = 1'b0;
        case (state)
            IDLE: begin
                inst_addr_ok = inst_req;
                if (inst_req) state_nx = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    inst_data_ok = 1'b1;
                    inst_addr_ok = inst_req;
                    state_nx     = inst_req ? LOOKUP : IDLE;
                end else begin
                    state_nx = AR;
                end
            end
            AR: begin
                axi_arvalid = 1'b1;
                if (axi_arready) state_nx = REFILL;
            end
            REFILL: begin
                axi_rready = 1'b1;
                if (axi_rvalid && axi_rlast) state_nx = DONE;
            end
            DONE: begin
                inst_data_ok = 1'b1;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // A request offered while reset is asserted would be dropped, so never acknowledge it.
        if (!resetn) inst_addr_ok = 1'b0;
    end

    assign axi_araddr = !axi_arvalid ? 32'd0 :
                        req_cache    ? {req_addr[31:OFF_BITS], {OFF_BITS{1'b0}}} : req_addr;
    assign axi_arlen  = (axi_arvalid && req_cache) ? 8'(LW - 1) : 8'd0;
    assign inst_rdata = !inst_data_ok  ? 32'd0 :
                        (state == DONE) ? cap_word : data_rd;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            valid     <= '0;
            cap_word  <= '0;
            req_addr  <= '0;
            req_cache <= 1'b0;
            beat_idx  <= '0;
        end else begin
            state <= state_nx;
            if (inst_addr_ok) begin
                req_addr  <= inst_addr;
                req_cache <= inst_cache;
            end
            if (state == AR)  beat_idx <= '0;
            else if (beat)    beat_idx <= beat_idx + 1'b1;
            if (beat && (!req_cache || beat_idx == req_word)) cap_word <= axi_rdata;
            if (tag_we) valid[req_idx] <= 1'b1;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP && req_cache) begin
            if (hit) hit_cnt  <= hit_cnt + 32'd1;
            else     miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: directed fetches, AXI slave model, decoupled data monitor.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0, inst_cache = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic        axi_arvalid, axi_rready;
    logic        axi_arready = 1'b0, axi_rlast = 1'b0, axi_rvalid = 1'b0;
    logic [31:0] axi_rdata = '0;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    icache_direct dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_cache   (inst_cache),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_rdata   (inst_rdata),
        .inst_data_ok (inst_data_ok),
        .axi_araddr   (axi_araddr),
        .axi_arlen    (axi_arlen),
        .axi_arvalid  (axi_arvalid),
        .axi_arready  (axi_arready),
        .axi_rdata    (axi_rdata),
        .axi_rlast    (axi_rlast),
        .axi_rvalid   (axi_rvalid),
        .axi_rready   (axi_rready)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        bit          hit;
        int          acc;
    } exp_t;
    typedef struct {
        logic [31:0] a;
        logic [7:0]  len;
    } ar_t;

    exp_t sbq[$];
    ar_t  arq[$];
    int   nchk = 0, npass = 0;
    int   cyc = 0, rlast_cyc = -100;
    int   ar_delay = 0, abort_beat = -1, unc_cnt = 0;
    bit   abort_hit = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic fail(input string nm);
        nchk++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // AXI read slave: cached lines return {d0d0, addr[15:0]}, uncached beats beef0000+n.
    initial forever begin
        ar_t e;
        @(posedge clk); #1;
        if (!resetn || !axi_arvalid) continue;
        if (arq.size() == 0) begin
            fail("unexpected_ar");
            e = '{axi_araddr, axi_arlen};
        end else begin
            e = arq.pop_front();
            chk("ar_addr", axi_araddr, e.a);
            chk("ar_len", {24'd0, axi_arlen}, {24'd0, e.len});
        end
        for (int k = 0; k < ar_delay; k++) begin
            chk("ar_hold_valid", axi_arvalid, 1);
            chk("ar_hold_addr", axi_araddr, e.a);
            chk("ar_hold_len", {24'd0, axi_arlen}, {24'd0, e.len});
            chk("ar_hold_addr_ok", inst_addr_ok, 0);
            @(posedge clk); #1;
        end
        axi_arready = 1'b1;
        @(posedge clk); #1;
        axi_arready = 1'b0;
        for (int i = 0; i <= int'(e.len); i++) begin
            axi_rvalid = 1'b1;
            axi_rlast  = (i == int'(e.len));
            axi_rdata  = (e.len == 8'd0) ? 32'hbeef0000 + unc_cnt
                                         : {16'hd0d0, e.a[15:0] + 16'(4 * i)};
            if (axi_rlast) rlast_cyc = cyc;
            if (i == abort_beat) abort_hit = 1'b1;
            chk("rready", axi_rready, 1);
            @(posedge clk); #1;
            if (!resetn) break;
        end
        if (e.len == 8'd0) unc_cnt++;
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
    end

    // Monitor: every data_ok pops one expected word and checks value and latency.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (inst_data_ok) begin
            if (sbq.size() == 0) begin
                fail("unexpected_data_ok");
            end else begin
                e = sbq.pop_front();
                chk("rdata", inst_rdata, e.d);
                if (e.hit) chk("hit_latency", cyc, e.acc + 1);
                else       chk("miss_latency", cyc, rlast_cyc + 1);
            end
        end else begin
            chk("rdata_zero_when_idle", inst_rdata, 0);
        end
    end

    task automatic issue(input logic [31:0] a, input logic c, input logic [31:0] d,
                         input bit hit, output int waited);
        bit ok = 1'b0;
        inst_req = 1'b1; inst_addr = a; inst_cache = c; waited = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (inst_addr_ok) begin ok = 1'b1; break; end
            waited++;
        end
        if (ok) sbq.push_back('{d, hit, cyc});
        else    fail("accept_timeout");
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && sbq.size() != 0; n++) @(negedge clk);
        if (sbq.size() != 0) begin
            fail("drain_timeout");
            sbq.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_outs_zero(input string nm);
        chk({nm, "_addr_ok"}, inst_addr_ok, 0);
        chk({nm, "_data_ok"}, inst_data_ok, 0);
        chk({nm, "_rdata"}, inst_rdata, 0);
        chk({nm, "_arvalid"}, axi_arvalid, 0);
        chk({nm, "_araddr"}, axi_araddr, 0);
        chk({nm, "_arlen"}, {24'd0, axi_arlen}, 0);
        chk({nm, "_rready"}, axi_rready, 0);
    endtask

    initial begin
        int  w;
        bit  seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outs_zero("reset");
        resetn = 1'b1;
        @(posedge clk); #1;

        // Cold miss, critical word is D1; then a hit on D2 of the same line.
        arq.push_back('{32'h1fc00100, 8'd3});
        issue(32'h1fc00104, 1'b1, 32'hd0d00104, 1'b0, w); inst_req = 1'b0; drain();
        issue(32'h1fc00108, 1'b1, 32'hd0d00108, 1'b1, w); inst_req = 1'b0; drain();

        // Four back-to-back hits with inst_req held high.
        for (int i = 0; i < 4; i++) begin
            issue(32'h1fc00100 + 32'(4 * i), 1'b1, 32'hd0d00100 + 32'(4 * i), 1'b1, w);
            chk("b2b_accept_wait", w, 0);
        end
        inst_req = 1'b0; drain();

        // Uncached fetches always go to the bus and never fill.
        arq.push_back('{32'h1fc00000, 8'd0});
        issue(32'h1fc00000, 1'b0, 32'hbeef0000, 1'b0, w); inst_req = 1'b0; drain();
        arq.push_back('{32'h1fc00000, 8'd0});
        issue(32'h1fc00000, 1'b0, 32'hbeef0001, 1'b0, w); inst_req = 1'b0; drain();
        arq.push_back('{32'h1fc00104, 8'd0});
        issue(32'h1fc00104, 1'b0, 32'hbeef0002, 1'b0, w); inst_req = 1'b0; drain();
        issue(32'h1fc00104, 1'b1, 32'hd0d00104, 1'b1, w); inst_req = 1'b0; drain();

        // Conflict on index 0: each fetch evicts the other.
        arq.push_back('{32'h00001000, 8'd3});
        issue(32'h00001000, 1'b1, 32'hd0d01000, 1'b0, w); inst_req = 1'b0; drain();
        arq.push_back('{32'h00003000, 8'd3});
        issue(32'h00003000, 1'b1, 32'hd0d03000, 1'b0, w); inst_req = 1'b0; drain();
        arq.push_back('{32'h00001000, 8'd3});
        issue(32'h00001000, 1'b1, 32'hd0d01000, 1'b0, w); inst_req = 1'b0; drain();

        // arready withheld 5 cycles while the CPU keeps requesting the next word.
        ar_delay = 5;
        arq.push_back('{32'h00005010, 8'd3});
        issue(32'h00005010, 1'b1, 32'hd0d05010, 1'b0, w);
        issue(32'h00005014, 1'b1, 32'hd0d05014, 1'b1, w);
        inst_req = 1'b0; drain();
        ar_delay = 0;

        // Reset while beat 2 of a refill is on the bus.
        abort_beat = 2;
        arq.push_back('{32'h00002040, 8'd3});
        issue(32'h00002048, 1'b1, 32'hd0d02048, 1'b0, w); inst_req = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (abort_hit) begin seen = 1'b1; break; end
        end
        if (!seen) fail("abort_beat_timeout");
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_outs_zero("mid_burst_reset");
        if (sbq.size() != 0) void'(sbq.pop_back());
        resetn = 1'b1; abort_beat = -1; abort_hit = 1'b0;
        @(posedge clk); #1;
        arq.push_back('{32'h00002040, 8'd3});
        issue(32'h00002048, 1'b1, 32'hd0d02048, 1'b0, w); inst_req = 1'b0; drain();
        arq.push_back('{32'h1fc00100, 8'd3});
        issue(32'h1fc00108, 1'b1, 32'hd0d00108, 1'b0, w); inst_req = 1'b0; drain();

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        chk("ar_queue_empty", arq.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
